// File: rtl/spi_cntrl_gen_if.sv
// ---------------------------------------------------------------------------
// spi_cntrl_gen_if
//   Bundles the user-side handshake and the SPI bus pins of spi_cntrl_gen.
//
//   Parameter:
//     DATA_WIDTH    bits per SPI word (must match the controller instance)
//
//   Signals:
//     start         request one word transfer
//     data_to_send  word to transmit, MSB first
//     hold_cs       keep SPI_CS low after the current word (multi-word frame)
//     cpol, cpha    SPI mode selection (only honoured when the controller
//                   is built with SPI_CNTRL_GEN_MODE_EN)
//     SPI_MISO      serial data from the subunit
//     data_received last complete received word
//     busy          controller not idle
//     done          one-cycle pulse at word completion
//     SPI_SCLK, SPI_MOSI, SPI_CS  registered SPI bus outputs
//
//   Modports:
//     master  the controller side (spi_cntrl_gen)
//     slave   the user / environment side
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface spi_cntrl_gen_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  start;
    logic [DATA_WIDTH-1:0] data_to_send;
    logic                  hold_cs;
    logic                  cpol;
    logic                  cpha;
    logic                  SPI_MISO;
    logic [DATA_WIDTH-1:0] data_received;
    logic                  busy;
    logic                  done;
    logic                  SPI_SCLK;
    logic                  SPI_MOSI;
    logic                  SPI_CS;

    modport master (
        input  start, data_to_send, hold_cs, cpol, cpha, SPI_MISO,
        output data_received, busy, done, SPI_SCLK, SPI_MOSI, SPI_CS
    );

    modport slave (
        output start, data_to_send, hold_cs, cpol, cpha, SPI_MISO,
        input  data_received, busy, done, SPI_SCLK, SPI_MOSI, SPI_CS
    );
endinterface

// File: rtl/spi_cntrl_gen.sv
// ---------------------------------------------------------------------------
// spi_cntrl_gen
//   SPI master controller. Transfers one DATA_WIDTH-bit word per start
//   request, MSB first, with optional chip-select hold for multi-word frames.
//
//   Parameters:
//     CLK_FREQUENCY   system clock in Hz
//     SCLK_FREQUENCY  SPI clock in Hz; HALF = CLK_FREQUENCY/(2*SCLK_FREQUENCY)
//                     system cycles per SCLK phase (must be >= 2)
//     DATA_WIDTH      bits per word (2..32)
//
//   Ports:
//     clk   system clock, everything changes on its rising edge
//     rst   asynchronous, active-high reset
//     bus   spi_cntrl_gen_if.master: start / data_to_send / hold_cs /
//           cpol / cpha / SPI_MISO in; data_received / busy / done /
//           SPI_SCLK / SPI_MOSI / SPI_CS out (all outputs registered)
//
//   Build option:
//     SPI_CNTRL_GEN_MODE_EN  when defined, cpol/cpha are latched at start and
//                            all four SPI modes are available; when undefined
//                            the controller runs in mode 0 only and ignores
//                            the cpol/cpha inputs.
//
//   Timing (HALF cycles per phase): SETUP, then per bit LEAD + TRAIL. The
//   final trailing edge is not followed by a TRAIL phase: the controller
//   finishes (done, data_received, CS release or HOLD) on that very edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module spi_cntrl_gen #(
    parameter int CLK_FREQUENCY  = 100_000_000,
    parameter int SCLK_FREQUENCY = 500_000,
    parameter int DATA_WIDTH     = 8
) (
    input  logic              clk,
    input  logic              rst,
    spi_cntrl_gen_if.master   bus
);

    localparam int HALF   = CLK_FREQUENCY / (2 * SCLK_FREQUENCY);
    localparam int HALF_W = $clog2(HALF + 1);
    localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(HALF - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LEAD,
        TRAIL,
        HOLD
    } state_t;

    // Mode inputs as seen by the controller
    logic mode_cpol;
    logic mode_cpha;

`ifdef SPI_CNTRL_GEN_MODE_EN
    assign mode_cpol = bus.cpol;
    assign mode_cpha = bus.cpha;
`else
    // Mode 0 only: the cpol/cpha pins exist but have no effect.
    assign mode_cpol = 1'b0;
    assign mode_cpha = 1'b0;
`endif

    state_t                state_q,   state_d;
    logic [HALF_W-1:0]     half_q,    half_d;
    logic [BIT_W-1:0]      bit_q,     bit_d;
    logic [DATA_WIDTH-1:0] tx_q,      tx_d;
    logic [DATA_WIDTH-1:0] rx_q,      rx_d;
    logic [DATA_WIDTH-1:0] data_rx_q, data_rx_d;
    logic                  cpol_q,    cpol_d;
    logic                  cpha_q,    cpha_d;
    logic                  sclk_q,    sclk_d;
    logic                  mosi_q,    mosi_d;
    logic                  cs_q,      cs_d;
    logic                  busy_q,    busy_d;
    logic                  done_q,    done_d;

    // Event strobes decoded from the state/phase timer
    logic                  half_end;
    logic                  load;
    logic                  lead_edge;
    logic                  trail_edge;
    logic                  last_bit;
    logic [DATA_WIDTH-1:0] rx_shift;

    assign half_end = (half_q == HALF_LAST);
    assign last_bit = (bit_q == BIT_LAST);
    assign rx_shift = {rx_q[DATA_WIDTH-2:0], bus.SPI_MISO};

    always_comb begin
        state_d    = state_q;
        half_d     = half_q;
        bit_d      = bit_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        data_rx_d  = data_rx_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        cs_d       = cs_q;
        done_d     = 1'b0;
        load       = 1'b0;
        lead_edge  = 1'b0;
        trail_edge = 1'b0;

        case (state_q)
            IDLE: begin
                // SCLK rests at the requested idle level so the subunit sees
                // the correct polarity before CS falls.
                sclk_d = mode_cpol;
                cs_d   = 1'b1;
                if (bus.start) begin
                    cpol_d = mode_cpol;
                    cpha_d = mode_cpha;
                    load   = 1'b1;
                end
            end

            SETUP: begin
                if (half_end) begin
                    lead_edge = 1'b1;
                    state_d   = LEAD;
                end else begin
                    half_d = half_q + HALF_W'(1);
                end
            end

            LEAD: begin
                if (half_end) begin
                    trail_edge = 1'b1;
                    state_d    = TRAIL;
                end else begin
                    half_d = half_q + HALF_W'(1);
                end
            end

            TRAIL: begin
                if (half_end) begin
                    bit_d     = bit_q + BIT_W'(1);
                    lead_edge = 1'b1;
                    state_d   = LEAD;
                end else begin
                    half_d = half_q + HALF_W'(1);
                end
            end

            HOLD: begin
                // CS stays asserted; the locked mode is kept for the next word.
                sclk_d = cpol_q;
                cs_d   = 1'b0;
                if (bus.start) begin
                    load = 1'b1;
                end else if (!bus.hold_cs) begin
                    cs_d    = 1'b1;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                cs_d    = 1'b1;
            end
        endcase

        // New word: first bit is presented immediately so that cpha=0 has
        // valid data on MOSI from the cycle CS falls.
        if (load) begin
            tx_d    = bus.data_to_send;
            mosi_d  = bus.data_to_send[DATA_WIDTH-1];
            rx_d    = '0;
            half_d  = '0;
            bit_d   = '0;
            cs_d    = 1'b0;
            state_d = SETUP;
        end

        if (lead_edge) begin
            half_d = '0;
            sclk_d = ~cpol_q;
            if (cpha_q) begin
                mosi_d = tx_q[DATA_WIDTH-1];
                tx_d   = tx_q << 1;
            end else begin
                rx_d = rx_shift;
            end
        end

        if (trail_edge) begin
            half_d = '0;
            sclk_d = cpol_q;
            if (cpha_q) begin
                rx_d = rx_shift;
            end else if (!last_bit) begin
                mosi_d = tx_q[DATA_WIDTH-2];
                tx_d   = tx_q << 1;
            end

            // Final trailing edge completes the word on the same cycle.
            if (last_bit) begin
                done_d    = 1'b1;
                data_rx_d = cpha_q ? rx_shift : rx_q;
                if (bus.hold_cs) begin
                    state_d = HOLD;
                end else begin
                    cs_d    = 1'b1;
                    state_d = IDLE;
                end
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            half_q    <= '0;
            bit_q     <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            data_rx_q <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            half_q    <= half_d;
            bit_q     <= bit_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            data_rx_q <= data_rx_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            cs_q      <= cs_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.data_received = data_rx_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.SPI_SCLK      = sclk_q;
    assign bus.SPI_MOSI      = mosi_q;
    assign bus.SPI_CS        = cs_q;

endmodule

// File: tb/tb_spi_cntrl_gen.sv
// ---------------------------------------------------------------------------
// tb_spi_cntrl_gen
//   Directed bench for spi_cntrl_gen: 100 MHz clock, 25 MHz SCLK (HALF=2).
//   One 8-bit instance (loopback or mode-3 subunit model) and one 16-bit
//   instance in loopback. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_spi_cntrl_gen;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    spi_cntrl_gen_if #(.DATA_WIDTH(8))  bus8 ();
    spi_cntrl_gen_if #(.DATA_WIDTH(16)) bus16 ();

    spi_cntrl_gen #(
        .CLK_FREQUENCY (100_000_000),
        .SCLK_FREQUENCY(25_000_000),
        .DATA_WIDTH    (8)
    ) u_dut8 (
        .clk(clk),
        .rst(rst),
        .bus(bus8)
    );

    spi_cntrl_gen #(
        .CLK_FREQUENCY (100_000_000),
        .SCLK_FREQUENCY(25_000_000),
        .DATA_WIDTH    (16)
    ) u_dut16 (
        .clk(clk),
        .rst(rst),
        .bus(bus16)
    );

    int vectors     = 0;
    int miscompares = 0;
    int done8       = 0;
    int done16      = 0;

    logic       loop       = 1'b1;
    logic       slave_miso = 1'b0;
    logic [7:0] slave_sr   = 8'h00;
    logic [7:0] cap8       = 8'h00;
    logic       frame      = 1'b0;
    logic       cs_seen_hi = 1'b0;

    assign bus8.SPI_MISO  = loop ? bus8.SPI_MOSI : slave_miso;
    assign bus16.SPI_MISO = bus16.SPI_MOSI;

    // Done pulse counters and CS continuity monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus8.done === 1'b1)  done8  <= done8 + 1;
        if (bus16.done === 1'b1) done16 <= done16 + 1;
        if (frame && bus8.SPI_CS !== 1'b0) cs_seen_hi <= 1'b1;
    end

    // Subunit view of MOSI: in modes 0 and 3 data is sampled on SCLK rising.
    always @(posedge bus8.SPI_SCLK) cap8 <= {cap8[6:0], bus8.SPI_MOSI};

    // Mode-3 subunit: shifts its reply out on the leading (falling) edge.
    always @(negedge bus8.SPI_SCLK) begin
        if (bus8.SPI_CS === 1'b0) begin
            slave_miso <= slave_sr[7];
            slave_sr   <= {slave_sr[6:0], 1'b0};
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One 8-bit word. Latency is counted in clock edges from the edge after
    // which start is raised; 0 means no done within the budget. data_to_send
    // is scrambled after acceptance; glitch_at pulses start mid-word.
    task automatic do_word(input logic [7:0] d, input logic hold,
                           input int glitch_at, output int lat);
        lat = 0;
        @(posedge clk); #1;
        bus8.start        = 1'b1;
        bus8.data_to_send = d;
        bus8.hold_cs      = hold;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            bus8.start        = (i == glitch_at);
            bus8.data_to_send = ~d;
            if (i == 1) begin
                chk("cs_low_after_start", bus8.SPI_CS, 1'b0);
                chk("busy_after_start", bus8.busy, 1'b1);
            end
            if (bus8.done === 1'b1) begin
                lat = i;
                break;
            end
        end
        bus8.start = 1'b0;
        $display("word tx=%02h hold=%0d latency=%0d rx=%02h", d, hold, lat, bus8.data_received);
    endtask

    int lat;
    int d0;

    initial begin
        bus8.start = 1'b0;  bus8.data_to_send = 8'h00;  bus8.hold_cs = 1'b0;
        bus8.cpol = 1'b0;   bus8.cpha = 1'b0;
        bus16.start = 1'b0; bus16.data_to_send = 16'h0000; bus16.hold_cs = 1'b0;
        bus16.cpol = 1'b0;  bus16.cpha = 1'b0;

        // Reset state
        #2 rst = 1'b1;
        #2;
        chk("rst_cs", bus8.SPI_CS, 1'b1);
        chk("rst_sclk", bus8.SPI_SCLK, 1'b0);
        chk("rst_mosi", bus8.SPI_MOSI, 1'b0);
        chk("rst_busy", bus8.busy, 1'b0);
        chk("rst_done", bus8.done, 1'b0);
        chk("rst_rx", bus8.data_received, 8'h00);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        // Basic mode-0 loopback word
        do_word(8'hA5, 1'b0, 0, lat);
        chk("a5_latency", lat, 33);
        chk("a5_rx", bus8.data_received, 8'hA5);
        chk("a5_cs_high_at_done", bus8.SPI_CS, 1'b1);
        chk("a5_sclk_idle", bus8.SPI_SCLK, 1'b0);
        chk("a5_mosi_seen", cap8, 8'hA5);
        @(posedge clk); #1;
        chk("a5_done_one_cycle", bus8.done, 1'b0);
        chk("a5_busy_after", bus8.busy, 1'b0);

        // Mode 3 (or ignored mode pins in the mode-0-only build)
        bus8.cpol = 1'b1;
        bus8.cpha = 1'b1;
        repeat (2) @(posedge clk); #1;
`ifdef SPI_CNTRL_GEN_MODE_EN
        loop     = 1'b0;
        slave_sr = 8'hC3;
        chk("m3_sclk_idle_before", bus8.SPI_SCLK, 1'b1);
        do_word(8'h3C, 1'b0, 0, lat);
        chk("m3_latency", lat, 33);
        chk("m3_rx", bus8.data_received, 8'hC3);
        chk("m3_mosi_seen", cap8, 8'h3C);
        chk("m3_sclk_at_done", bus8.SPI_SCLK, 1'b1);
        @(posedge clk); #1;
        chk("m3_sclk_idle_after", bus8.SPI_SCLK, 1'b1);
        loop = 1'b1;
`else
        chk("m0only_sclk_idle_before", bus8.SPI_SCLK, 1'b0);
        do_word(8'h3C, 1'b0, 0, lat);
        chk("m0only_latency", lat, 33);
        chk("m0only_rx", bus8.data_received, 8'h3C);
        chk("m0only_mosi_seen", cap8, 8'h3C);
        @(posedge clk); #1;
        chk("m0only_sclk_idle_after", bus8.SPI_SCLK, 1'b0);
`endif
        bus8.cpol = 1'b0;
        bus8.cpha = 1'b0;
        repeat (2) @(posedge clk);

        // Multi-word frame with CS held
        d0 = done8;
        do_word(8'h12, 1'b1, 0, lat);
        chk("h1_latency", lat, 33);
        chk("h1_rx", bus8.data_received, 8'h12);
        chk("h1_cs_held", bus8.SPI_CS, 1'b0);
        frame = 1'b1;
        do_word(8'h34, 1'b1, 0, lat);
        chk("h2_latency", lat, 33);
        chk("h2_rx", bus8.data_received, 8'h34);
        do_word(8'h56, 1'b1, 0, lat);
        chk("h3_latency", lat, 33);
        chk("h3_rx", bus8.data_received, 8'h56);
        @(posedge clk); #1;
        chk("hold_sclk_idle", bus8.SPI_SCLK, 1'b0);
        chk("hold_busy", bus8.busy, 1'b1);
        bus8.hold_cs = 1'b0;
        @(posedge clk); #1;
        frame = 1'b0;
        chk("hold_release_cs", bus8.SPI_CS, 1'b1);
        chk("hold_release_busy", bus8.busy, 1'b0);
        chk("hold_cs_continuous", cs_seen_hi, 1'b0);
        chk("hold_done_count", done8 - d0, 3);

        // Start pulsed mid-word is ignored
        d0 = done8;
        do_word(8'h5A, 1'b0, 10, lat);
        chk("glitch_latency", lat, 33);
        chk("glitch_rx", bus8.data_received, 8'h5A);
        chk("glitch_mosi_seen", cap8, 8'h5A);
        repeat (40) @(posedge clk); #1;
        chk("glitch_done_count", done8 - d0, 1);
        chk("glitch_idle", bus8.busy, 1'b0);

        // Reset in the middle of a word (bit 4 of 0xFF)
        d0 = done8;
        @(posedge clk); #1;
        bus8.start = 1'b1; bus8.data_to_send = 8'hFF; bus8.hold_cs = 1'b0;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        repeat (18) @(posedge clk);
        #3;
        chk("abort_busy_before", bus8.busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("abort_cs", bus8.SPI_CS, 1'b1);
        chk("abort_sclk", bus8.SPI_SCLK, 1'b0);
        chk("abort_mosi", bus8.SPI_MOSI, 1'b0);
        chk("abort_busy", bus8.busy, 1'b0);
        chk("abort_done", bus8.done, 1'b0);
        chk("abort_rx", bus8.data_received, 8'h00);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (40) @(posedge clk); #1;
        chk("abort_no_done", done8 - d0, 0);
        do_word(8'h0F, 1'b0, 0, lat);
        chk("after_rst_latency", lat, 33);
        chk("after_rst_rx", bus8.data_received, 8'h0F);
        chk("after_rst_mosi_seen", cap8, 8'h0F);

        // 16-bit instance
        d0  = done16;
        lat = 0;
        @(posedge clk); #1;
        bus16.start = 1'b1; bus16.data_to_send = 16'hBEEF; bus16.hold_cs = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk); #1;
            bus16.start        = 1'b0;
            bus16.data_to_send = 16'h0000;
            if (bus16.done === 1'b1) begin
                lat = i;
                break;
            end
        end
        $display("word16 tx=BEEF latency=%0d rx=%04h", lat, bus16.data_received);
        chk("w16_latency", lat, 65);
        chk("w16_rx", bus16.data_received, 16'hBEEF);
        chk("w16_cs_high_at_done", bus16.SPI_CS, 1'b1);
        repeat (4) @(posedge clk); #1;
        chk("w16_done_count", done16 - d0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
